golden_nonce_queue: RTL and testbench
=====================================

Name: golden_nonce_queue

Overview:
- Sits between the hashing control unit and serial_transmit: captures every golden-nonce event from the miner and delivers each one to the UART in order, one 32-bit word at a time.
- Raw nonces are corrected for the keccak pipeline latency before they are queued.
- Enforces the serial_send/serial_busy handshake, so back-to-back matches are never lost or overwritten while the UART is busy.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- NONCE_OFFSET, 32'd49, subtracted from the raw nonce to compensate for hash pipeline latency.
- BUSY_TIMEOUT, 16, cycles to wait for busy to rise after a send pulse before the word is treated as accepted.

Ports:
- clk  input  1  hash/uart clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- found  input  1  one-cycle pulse: a golden nonce (or exhaustion nonce) is present on raw_nonce.
- raw_nonce  input  32  nonce value sampled when found=1.
- serial_busy  input  1  busy from serial_transmit.
- serial_send  output  1  one-cycle send strobe to serial_transmit.
- word  output  32  corrected nonce presented to serial_transmit; stable from the send pulse until the word is retired.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- drop_count  output  8  count of nonces lost to overflow; saturates at 255.

Behaviour:
Reset (asynchronous, active-high):
- serial_send=0, word=0, empty=1, full=0, drop_count=0.
- Read and write pointers are cleared; FSM goes to IDLE.
- Reset mid-transmission discards all queued entries. serial_transmit finishes its current frame on its own.

Push path:
- On found=1 with !full, write raw_nonce - NONCE_OFFSET (mod 2^32) at the write pointer.
- Wrap-around example: raw 32'h0000_0010 - 49 = 32'hFFFF_FFDF.
- found=1 with full=1: the entry is dropped and drop_count increments, saturating at 8'hFF.
- Push and pop in the same cycle are both honoured. Occupancy is unchanged, and full=1 still accepts a push when a pop happens that cycle.
- Pointers are log2(DEPTH)+1 bits. full and empty are registered and derived from the pointers.

FSM:
- IDLE: if !empty and !serial_busy, latch the FIFO head into word and go to SEND.
- SEND: serial_send=1 for exactly one cycle, clear the timeout counter, go to WAIT_HI.
- WAIT_HI:
  - serial_busy=1: go to WAIT_LO.
  - Otherwise, when the counter reaches BUSY_TIMEOUT-1, retire the entry and go to IDLE.
- WAIT_LO: when serial_busy=0, retire the entry (pop, advance the read pointer) and go to IDLE.

Timing and ordering:
- Minimum latency from found to serial_send is 3 cycles (write, IDLE latch, SEND), given an idle UART.
- Strict FIFO order. An entry is popped only on retire, never on latch.
- serial_send is never asserted while serial_busy=1 in IDLE.

Optional Feature:
- Macro: GNQ_DEDUP_EN.
- Defined:
  - A register holds the last accepted corrected nonce, with a valid flag cleared by reset.
  - A push whose corrected value equals that register is silently discarded; drop_count is not incremented.
  - This suppresses duplicate reports when a match is re-signalled for the same nonce.
- Undefined: every found pulse is queued or counted as dropped.

Test Plan:
- Single push: reset, found with raw_nonce=32'h0000_1000, busy model responds 1 cycle after send with a 10-cycle busy -> serial_send exactly once, 3 cycles after found; word=32'h0000_0FCF; empty=1 after busy falls.
- Burst order: 4 found pulses on consecutive cycles (raw 100, 200, 300, 400) with the UART busy -> four sends in order, words 51, 151, 251, 351; no send while busy=1.
- Overflow: DEPTH=8, hold busy=1, issue 11 pushes -> full=1 after 8, drop_count=3; the first 8 values are delivered in order once busy releases.
- Offset wrap: raw_nonce=32'h0000_0000 -> word=32'hFFFF_FFCF.
- Timeout: busy tied 0 -> each entry is retired BUSY_TIMEOUT cycles after its send pulse; 2 entries give 2 sends 18 cycles apart (default parameters).
- Async reset: assert reset in WAIT_LO with 3 entries queued -> outputs return to reset values immediately without a clock; no further sends; drop_count=0.
- GNQ_DEDUP_EN: push raw 500 twice, then raw 501 -> only words 451 and 452 sent; drop_count=0.

Source files
------------

// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue
//
// Buffers golden-nonce events from the hashing control unit and hands them
// to serial_transmit one 32-bit word at a time, in arrival order.
//
// Each raw nonce has NONCE_OFFSET subtracted (mod 2^32) to undo the keccak
// pipeline latency before it is written into a DEPTH-entry FIFO. A small FSM
// drives the serial_send / serial_busy handshake:
//   IDLE    -> wait for an entry and an idle UART, latch the head into word
//   SEND    -> one-cycle send strobe
//   WAIT_HI -> wait for busy to rise; give up after BUSY_TIMEOUT cycles
//   WAIT_LO -> wait for busy to fall
// The head entry is popped only when it is retired (end of WAIT_HI timeout or
// end of WAIT_LO), so a word is never lost while the UART is busy.
//
// Optional feature macro: GNQ_DEDUP_EN
//   When defined, a push whose corrected value equals the last accepted
//   corrected nonce is silently discarded (drop_count is not incremented).
//
// Ports:
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous, active-high reset
//   found       in   1   one-cycle pulse, raw_nonce is valid
//   raw_nonce   in  32   nonce sampled when found=1
//   serial_busy in   1   busy from serial_transmit
//   serial_send out  1   one-cycle send strobe to serial_transmit
//   word        out 32   corrected nonce, stable from send until retire
//   empty       out  1   FIFO holds no entries
//   full        out  1   FIFO holds DEPTH entries
//   drop_count  out  8   nonces lost to overflow, saturates at 255

module golden_nonce_queue #(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] NONCE_OFFSET = 32'd49,
  parameter int          BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        found,
  input  logic [31:0] raw_nonce,
  input  logic        serial_busy,
  output logic        serial_send,
  output logic [31:0] word,
  output logic        empty,
  output logic        full,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_END = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          latch;
  logic          retire;
  logic          send_next;
  logic          cnt_clr;
  logic [CW-1:0] cnt;

  logic [31:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_next;
  logic [AW:0]   rd_next;

  logic [31:0]   corrected;
  logic          dup;
  logic          push_ok;
  logic          drop;

  assign corrected = raw_nonce - NONCE_OFFSET;

`ifdef GNQ_DEDUP_EN
  logic [31:0] last_nonce;
  logic        last_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_nonce <= 32'd0;
      last_valid <= 1'b0;
    end else if (push_ok) begin
      last_nonce <= corrected;
      last_valid <= 1'b1;
    end
  end

  assign dup = last_valid && (corrected == last_nonce);
`else
  assign dup = 1'b0;
`endif

  // A full FIFO still accepts a push in the cycle its head is retired.
  assign push_ok = found && !dup && (!full || retire);
  assign drop    = found && !dup && full && !retire;

  assign wr_next = push_ok ? (wr_ptr + PTR_ONE) : wr_ptr;
  assign rd_next = retire  ? (rd_ptr + PTR_ONE) : rd_ptr;

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= corrected;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    retire     = 1'b0;
    send_next  = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !serial_busy) begin
          latch      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        // serial_send is registered, so it is high during the WAIT_HI
        // cycle that follows SEND.
        send_next  = 1'b1;
        cnt_clr    = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (serial_busy) begin
          state_next = WAIT_LO;
        end else if (cnt == CNT_END) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_LO: begin
        if (!serial_busy) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      serial_send <= 1'b0;
      word        <= 32'd0;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      state       <= state_next;
      serial_send <= send_next;
      if (latch) begin
        word <= mem[rd_ptr[AW-1:0]];
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (state == WAIT_HI) begin
        cnt <= cnt + CNT_ONE;
      end
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      empty  <= (wr_next == rd_next);
      full   <= (wr_next[AW] != rd_next[AW]) &&
                (wr_next[AW-1:0] == rd_next[AW-1:0]);
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Testbench for golden_nonce_queue.
// Directed scenarios plus randomized bursts, checked against a queue-based
// reference model and a behavioural serial_transmit busy responder.

module tb_golden_nonce_queue;

  localparam int          DEPTH = 8;
  localparam logic [31:0] OFFS  = 32'd49;
`ifdef GNQ_DEDUP_EN
  localparam int DEDUP_SENDS = 2;
`else
  localparam int DEDUP_SENDS = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        found;
  logic [31:0] raw_nonce;
  wire         serial_busy;
  logic        serial_send;
  logic [31:0] word;
  logic        empty;
  logic        full;
  logic [7:0]  drop_count;

  logic        force_busy;
  logic        uart_busy;

  assign serial_busy = force_busy | uart_busy;

  always #5 clk = ~clk;

  golden_nonce_queue dut (
    .clk         (clk),
    .reset       (reset),
    .found       (found),
    .raw_nonce   (raw_nonce),
    .serial_busy (serial_busy),
    .serial_send (serial_send),
    .word        (word),
    .empty       (empty),
    .full        (full),
    .drop_count  (drop_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: words still to be sent, drops, last accepted value.
  logic [31:0] exp_q[$];
  int          model_drops = 0;
  bit          has_last = 0;
  logic [31:0] last_val = 32'd0;

  task automatic model_push(input logic [31:0] raw);
    logic [31:0] corr;
    bit          skip;
    corr = raw - OFFS;
    skip = 0;
`ifdef GNQ_DEDUP_EN
    if (has_last && corr == last_val) skip = 1;
`endif
    if (!skip) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(corr);
        has_last = 1;
        last_val = corr;
      end else if (model_drops < 255) begin
        model_drops++;
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_drops = 0;
    has_last    = 0;
  endtask

  // serial_transmit stand-in: busy rises busy_delay cycles after a send
  // pulse and stays high for busy_len cycles. mute=1 never raises busy.
  int busy_delay = 1;
  int busy_len   = 10;
  bit mute       = 0;

  initial begin
    int delay_left;
    int len_left;
    delay_left = 0;
    len_left   = 0;
    uart_busy  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (uart_busy) begin
        len_left--;
        if (len_left <= 0) uart_busy = 1'b0;
      end else if (delay_left > 0) begin
        delay_left--;
        if (delay_left == 0) begin
          uart_busy = 1'b1;
          len_left  = busy_len;
        end
      end
      if (serial_send === 1'b1 && !mute) delay_left = busy_delay;
    end
  end

  // Send monitor / scoreboard.
  int send_cnt      = 0;
  int last_send_cyc = 0;

  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (reset === 1'b0 && serial_send === 1'b1) begin
        send_cnt++;
        last_send_cyc = cyc;
        $display("send %0d at cyc %0d word=%h", send_cnt, cyc, word);
        check("send_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("send_word", word, e);
        end
        check("send_while_busy", 32'(serial_busy), 32'd0);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] raw);
    found     = 1'b1;
    raw_nonce = raw;
    model_push(raw);
    tick();
    found     = 1'b0;
    raw_nonce = $urandom;
  endtask

  task automatic wait_send(input int sc, input string tag);
    int t;
    t = 0;
    while (send_cnt == sc && t < 200) begin
      tick();
      t++;
    end
    check({tag, "_send_seen"}, 32'(send_cnt != sc), 32'd1);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    check({tag, "_all_sent"}, 32'(exp_q.size()), 32'd0);
    t = 0;
    while (empty !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    check({tag, "_empty"}, 32'(empty), 32'd1);
    tick(2);
  endtask

  initial begin
    int sc;
    int c0;
    int s1;
    int n;
    logic [31:0] raw;

    reset      = 1'b1;
    found      = 1'b0;
    raw_nonce  = 32'd0;
    force_busy = 1'b0;
    tick(3);
    check("rst_send",  32'(serial_send), 32'd0);
    check("rst_word",  word, 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    reset = 1'b0;
    tick(2);

    // Single push: latency 3, corrected word, one send only.
    busy_delay = 1;
    busy_len   = 10;
    sc = send_cnt;
    c0 = cyc;
    push(32'h0000_1000);
    wait_send(sc, "t1");
    check("t1_latency", 32'(last_send_cyc - c0), 32'd3);
    check("t1_word", word, 32'h0000_0FCF);
    drain("t1");
    check("t1_sends", 32'(send_cnt - sc), 32'd1);

    // Burst while UART is busy.
    sc = send_cnt;
    force_busy = 1'b1;
    push(32'd100);
    push(32'd200);
    push(32'd300);
    push(32'd400);
    tick(3);
    check("t2_no_send_busy", 32'(send_cnt - sc), 32'd0);
    force_busy = 1'b0;
    busy_len   = 5;
    drain("t2");
    check("t2_sends", 32'(send_cnt - sc), 32'd4);

    // Overflow: 11 pushes into a stalled queue.
    sc = send_cnt;
    force_busy = 1'b1;
    for (int i = 0; i < 11; i++) begin
      push(32'd1000 + 32'(i * 7));
      if (i == 6) check("t3_not_full", 32'(full), 32'd0);
      if (i == 7) check("t3_full", 32'(full), 32'd1);
    end
    check("t3_drops", 32'(drop_count), 32'd3);
    check("t3_full_after", 32'(full), 32'd1);
    force_busy = 1'b0;
    drain("t3");
    check("t3_sends", 32'(send_cnt - sc), 32'd8);
    check("t3_drops_kept", 32'(drop_count), 32'(model_drops));

    // Offset wrap-around.
    sc = send_cnt;
    push(32'h0000_0000);
    wait_send(sc, "t4");
    check("t4_word", word, 32'hFFFF_FFCF);
    drain("t4");

    // Timeout: busy never rises.
    mute = 1;
    sc = send_cnt;
    push(32'h1234_5678);
    push(32'h8765_4321);
    wait_send(sc, "t5a");
    s1 = last_send_cyc;
    wait_send(sc + 1, "t5b");
    check("t5_spacing", 32'(last_send_cyc - s1), 32'd18);
    drain("t5");
    mute = 0;

    // Asynchronous reset in WAIT_LO with 3 entries queued.
    busy_len = 40;
    sc = send_cnt;
    push(32'hA000_0000);
    push(32'hA000_0001);
    push(32'hA000_0002);
    wait_send(sc, "t6");
    tick(5);
    #3;
    reset = 1'b1;
    #1;
    check("t6_send",  32'(serial_send), 32'd0);
    check("t6_word",  word, 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_full",  32'(full), 32'd0);
    check("t6_drops", 32'(drop_count), 32'd0);
    model_clear();
    tick(2);
    reset = 1'b0;
    sc = send_cnt;
    tick(60);
    check("t6_no_sends", 32'(send_cnt - sc), 32'd0);
    busy_len = 6;

    // Duplicate suppression (or not, when the feature is off).
    sc = send_cnt;
    push(32'd500);
    tick(2);
    push(32'd500);
    tick(1);
    push(32'd501);
    drain("t7");
    check("t7_sends", 32'(send_cnt - sc), 32'(DEDUP_SENDS));
    check("t7_drops", 32'(drop_count), 32'd0);

    // Randomized bursts, never more than DEPTH outstanding.
    for (int r = 0; r < 25; r++) begin
      mute       = ($urandom_range(0, 3) == 0);
      busy_delay = $urandom_range(1, 3);
      busy_len   = $urandom_range(1, 12);
      n          = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) == 0) raw = 32'($urandom_range(0, 48));
        else raw = $urandom;
        push(raw);
        tick($urandom_range(0, 3));
      end
      drain("rnd");
      check("rnd_drops", 32'(drop_count), 32'(model_drops));
    end
    mute = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
